// File: rtl/adder_pkg.sv
// Shared constants for the carry-lookahead adder.
package adder_pkg;

   localparam int unsigned GROUP_W = 4;
   localparam int unsigned ADDER_W = 32;

endpackage : adder_pkg

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: sum bits plus group generate/propagate.
module cla_group4
   import adder_pkg::*;
(
   input  logic [GROUP_W-1:0] a,
   input  logic [GROUP_W-1:0] b,
   input  logic               cin,
   output logic [GROUP_W-1:0] s,
   output logic               G,
   output logic               P
);

   logic [GROUP_W-1:0] g;
   logic [GROUP_W-1:0] p;
   logic [GROUP_W-1:0] c;

   // Bit generate/propagate, flattened internal carries, sums and group G/P.
   always_comb begin
      g = a & b;
      p = a ^ b;

      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & cin);

      s = p ^ c;

      G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
        | (p[3] & p[2] & p[1] & g[0]);
      P = &p;
   end

endmodule : cla_group4

// File: rtl/adder_cla.sv
// Registered WIDTH-bit two-level carry-lookahead adder: {c_out,sum} = a+b+c_in.
module adder_cla
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = ADDER_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             c_out,
   output logic [WIDTH-1:0] sum
);

   localparam int unsigned NG = WIDTH / GROUP_W;

   logic [NG-1:0]    grp_g;
   logic [NG-1:0]    grp_p;
   logic [NG:0]      grp_c;
   logic [WIDTH-1:0] sum_d;
   logic [WIDTH-1:0] sum_q;
   logic             c_out_d;
   logic             c_out_q;
   logic             term;
   logic             acc;

   for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      cla_group4 u_grp (
         .a   (a[gi*GROUP_W +: GROUP_W]),
         .b   (b[gi*GROUP_W +: GROUP_W]),
         .cin (grp_c[gi]),
         .s   (sum_d[gi*GROUP_W +: GROUP_W]),
         .G   (grp_g[gi]),
         .P   (grp_p[gi])
      );
   end

   // Group carries as flattened sum-of-products over group G/P and c_in:
   // c[k+1] = G[k] | P[k]G[k-1] | ... | P[k..0]c_in, each term built independently.
   always_comb begin
      grp_c    = '0;
      term     = 1'b0;
      acc      = 1'b0;
      grp_c[0] = c_in;
      for (int unsigned k = 0; k < NG; k++) begin
         acc = c_in;
         for (int unsigned m = 0; m <= k; m++) begin
            acc = acc & grp_p[m];
         end
         for (int unsigned j = 0; j <= k; j++) begin
            term = grp_g[j];
            for (int unsigned m = j + 1; m <= k; m++) begin
               term = term & grp_p[m];
            end
            acc = acc | term;
         end
         grp_c[k+1] = acc;
      end
   end

   assign c_out_d = grp_c[NG];

   // Output registers; reset clears the result and overrides the new sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q   <= '0;
         c_out_q <= 1'b0;
      end else begin
         sum_q   <= sum_d;
         c_out_q <= c_out_d;
      end
   end

   assign sum   = sum_q;
   assign c_out = c_out_q;

endmodule : adder_cla

// File: tb/tb_adder_cla.sv
// Self-checking bench for adder_cla at WIDTH=32 and WIDTH=8 side by side.
module tb_adder_cla;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a32, b32, sum32;
   logic        c32, co32;
   logic [7:0]  a8, b8, sum8;
   logic        c8, co8;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   adder_cla #(.WIDTH(32)) u_dut32 (
      .clk   (clk),
      .rst   (rst),
      .a     (a32),
      .b     (b32),
      .c_in  (c32),
      .c_out (co32),
      .sum   (sum32)
   );

   adder_cla #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst   (rst),
      .a     (a8),
      .b     (b8),
      .c_in  (c8),
      .c_out (co8),
      .sum   (sum8)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Present both operand sets for one edge, then compare against plain arithmetic.
   task automatic step(input string tag, input logic r,
                       input logic [31:0] ia32, input logic [31:0] ib32, input logic ic32,
                       input logic [7:0] ia8, input logic [7:0] ib8, input logic ic8);
      logic [32:0] exp32;
      logic [8:0]  exp8;
      rst = r;
      a32 = ia32; b32 = ib32; c32 = ic32;
      a8  = ia8;  b8  = ib8;  c8  = ic8;
      exp32 = r ? 33'd0 : ({1'b0, ia32} + {1'b0, ib32} + {32'd0, ic32});
      exp8  = r ? 9'd0  : ({1'b0, ia8} + {1'b0, ib8} + {8'd0, ic8});
      @(posedge clk);
      #1;
      check_eq({tag, "/w32"}, {31'd0, co32, sum32}, {31'd0, exp32});
      check_eq({tag, "/w8"},  {55'd0, co8, sum8},   {55'd0, exp8});
   endtask

   initial begin
      rst = 1'b1;
      a32 = '0; b32 = '0; c32 = 1'b0;
      a8  = '0; b8  = '0; c8  = 1'b0;

      for (int i = 0; i < 3; i++)
         step("reset", 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b1, 8'hFF, 8'h1, 1'b1);

      step("full_prop",   1'b0, 32'hFFFF_FFFF, 32'h0,         1'b1, 8'hFF, 8'h00, 1'b1);
      step("maximum",     1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 8'hFF, 8'hFF, 1'b1);
      step("grp_bound0",  1'b0, 32'h0000_000F, 32'h1,         1'b0, 8'h0F, 8'h01, 1'b0);
      step("grp_bound1",  1'b0, 32'h0FFF_FFFF, 32'h1,         1'b0, 8'h7F, 8'h01, 1'b0);
      step("b2b_first",   1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 8'h78, 8'hF0, 1'b0);
      step("b2b_second",  1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 8'h80, 8'h80, 1'b1);

      // Known constants for the back-to-back pair, independent of the model.
      step("b2b_known",   1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 8'h00, 8'h00, 1'b0);
      check_eq("b2b_const0", {31'd0, co32, sum32}, {31'd0, 1'b0, 32'hACF1_3568});
      step("b2b_known2",  1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 8'h00, 8'h00, 1'b0);
      check_eq("b2b_const1", {31'd0, co32, sum32}, {31'd0, 1'b1, 32'h0000_0001});

      // Reset in mid-stream must override a carry-generating operation.
      step("mid_reset",   1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 8'hFF, 8'hFF, 1'b1);

      for (int i = 0; i < 10000; i++)
         step("random", 1'b0, 32'($urandom), 32'($urandom), 1'($urandom),
              8'($urandom), 8'($urandom), 1'($urandom));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_adder_cla

// File: doc/adder_cla.md
# adder_cla

Registered 32-bit carry-lookahead adder computing `a + b + c_in` with carry-out. It is a self-contained datapath leaf for integer arithmetic paths that need a fast adder: a hierarchical (two-level) lookahead carry network replaces ripple carry. Results are captured in output registers, one clock after the operands are presented.

## Interface
- `WIDTH`, default 32: operand/sum width in bits; must be a positive multiple of 4.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `a`  input  WIDTH  addend A, unsigned.
- `b`  input  WIDTH  addend B, unsigned.
- `c_in`  input  1  carry into bit 0.
- `c_out`  output  1  registered carry out of bit WIDTH-1.
- `sum`  output  WIDTH  registered sum bits [WIDTH-1:0].

## Operation
- Per bit: generate `g[i] = a[i] & b[i]`, propagate `p[i] = a[i] ^ b[i]`.
- Bits grouped in 4-bit groups. Each group computes:
  - internal carries `c[i+1] = g[i] | p[i]&c[i]` in flattened lookahead form, with no ripple;
  - group generate `G` and group propagate `P`.
- Second level: group carries are computed by lookahead over the group `G`/`P` from `c_in`.
  - When `WIDTH/4 > 4`, groups are clustered in fours, with a third level as needed.
  - Alternatively, the full group-carry chain is computed as flattened lookahead equations.
  - Either way, the carry path contains no bit-serial ripple.
- `sum[i] = p[i] ^ c[i]`, with `c[0] = c_in`.
- `c_out` is the carry out of the top group.
- Arithmetic is unsigned modulo 2^WIDTH: `{c_out, sum} = a + b + c_in`, exact for all inputs.
- No overflow flag; signed overflow is the caller's concern.
- Inputs are not registered inside the block.
- X on inputs is not guarded; inputs are required to be known when sampled.

## Timing
- Latency: 1 cycle. Operands and `c_in` stable before rising edge N give a result visible on `sum`/`c_out` after edge N.
- Throughput: one new operation per cycle, no handshake, no stall.
- Reset: `rst` high at a rising edge forces `sum = 0` and `c_out = 0`.
  - Reset overrides the computed result on that edge.
  - The first valid result appears one edge after `rst` deasserts, for operands presented at that edge.
- Before the first edge (no reset applied), outputs are undefined.
- The combinational path a/b/c_in → registers must close within one clock period. The lookahead depth is O(log WIDTH) to meet this.

## Structure
- Sub-module `cla_group4`: 4-bit lookahead group.
  - Inputs: `a[3:0]`, `b[3:0]`, `cin`.
  - Outputs: `s[3:0]`, `G`, `P`.
- A generate loop in the top level instantiates `WIDTH/4` copies of `cla_group4`.
- Group-carry lookahead logic and output registers live in the top level.
- Shared package `adder_pkg` holds the `GROUP_W = 4` constant and the default-width constant `ADDER_W = 32`. No typedefs are needed.

## Test plan
- Reset: hold `rst=1` with `a=0xFFFFFFFF`, `b=1`, `c_in=1` → `sum=0x00000000`, `c_out=0` on every edge while reset is held.
- Full carry propagation: `a=0xFFFFFFFF`, `b=0`, `c_in=1` → one cycle later `sum=0x00000000`, `c_out=1`.
- Maximum: `a=0xFFFFFFFF`, `b=0xFFFFFFFF`, `c_in=1` → `sum=0xFFFFFFFF`, `c_out=1`.
- Group-boundary carry: `a=0x0000000F`, `b=0x00000001`, `c_in=0` → `sum=0x00000010`, `c_out=0`. Also `a=0x0FFFFFFF`, `b=1` → `sum=0x10000000`, `c_out=0`.
- Back-to-back: present `(0x12345678, 0x9ABCDEF0, 0)` then `(0x80000000, 0x80000000, 1)` on consecutive cycles → outputs `sum=0xACF13568`, `c_out=0`, then `sum=0x00000001`, `c_out=1`, each one cycle after its inputs.
- Random: each cycle apply random `a`/`b` and random 1-bit `c_in` for ≥10,000 cycles → every output matches a reference model `{c_out,sum} = a+b+c_in` from the previous cycle. Repeat the sweep with `WIDTH=8`.
